// File: rtl/usb_rx_timer_if.sv
// Receive-timer bundle between the RX line front end, the unstuffer and the RX timer.
// The master side drives the line/control inputs; the slave side (the timer) drives the strobes.
interface usb_rx_timer_if;
  logic       rcving;
  logic       d_plus_sync;
  logic       stuff_bit;
  logic       shift_enable;
  logic       byte_received;
  logic [2:0] bit_count;
  logic       drift_err;

  modport master (
    output rcving,
    output d_plus_sync,
    output stuff_bit,
    input  shift_enable,
    input  byte_received,
    input  bit_count,
    input  drift_err
  );

  modport slave (
    input  rcving,
    input  d_plus_sync,
    input  stuff_bit,
    output shift_enable,
    output byte_received,
    output bit_count,
    output drift_err
  );
endinterface

// File: rtl/usb_rx_timer.sv
// USB RX bit/byte timer: resyncs phase on every D+ transition, strobes shift_enable SAMPLE_POINT
// cycles after resync, byte_received one cycle after the 8th data bit; no backpressure. Optional USB_RX_DRIFT_DETECT_EN.
module usb_rx_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic         clk,
  input  logic         rst,
  usb_rx_timer_if.slave rx
);

  localparam int PH_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_POINT);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("usb_rx_timer: CLKS_PER_BIT must be >= 4");
    end
    if (SAMPLE_POINT < 1 || SAMPLE_POINT > CLKS_PER_BIT - 1) begin : g_bad_sp
      $error("usb_rx_timer: SAMPLE_POINT must be in 1..CLKS_PER_BIT-1");
    end
  endgenerate

  logic            d_prev;
  logic            line_edge;
  logic            strobe;
  logic            data_bit;
  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;
  logic [2:0]      bc;
  logic [2:0]      bc_nxt;
  logic            byte_q;
  logic            byte_nxt;

  // The edge cycle counts as phase 0, so a sample landing on an edge is dropped.
  always_comb begin
    line_edge = rx.d_plus_sync ^ d_prev;
    strobe    = rx.rcving & ~line_edge & (ph == PH_SAMPLE);
    data_bit  = strobe & ~rx.stuff_bit;
  end

  always_comb begin
    ph_nxt = ph + PH_ONE;
    if (!rx.rcving) begin
      ph_nxt = '0;
    end else if (line_edge) begin
      ph_nxt = PH_ONE;
    end else if (ph == PH_LAST) begin
      ph_nxt = '0;
    end
  end

  // Stuffed bits are strobed into the unstuffer but never counted toward the byte.
  always_comb begin
    bc_nxt = bc;
    if (!rx.rcving) begin
      bc_nxt = 3'd0;
    end else if (data_bit) begin
      bc_nxt = bc + 3'd1;
    end
  end

  always_comb begin
    byte_nxt = rx.rcving & data_bit & (bc == 3'd7);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_prev <= 1'b1;
      ph     <= '0;
      bc     <= 3'd0;
      byte_q <= 1'b0;
    end else begin
      d_prev <= rx.d_plus_sync;
      ph     <= ph_nxt;
      bc     <= bc_nxt;
      byte_q <= byte_nxt;
    end
  end

  assign rx.shift_enable  = strobe;
  assign rx.byte_received = byte_q;
  assign rx.bit_count     = bc;

`ifdef USB_RX_DRIFT_DETECT_EN
  logic drift_q;
  logic bad_edge;

  // An edge within one clock of the expected bit boundary is normal jitter.
  always_comb begin
    bad_edge = rx.rcving & line_edge &
               ~((ph == PH_LAST) | (ph == '0) | (ph == PH_ONE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drift_q <= 1'b0;
    end else if (!rx.rcving) begin
      drift_q <= 1'b0;
    end else if (bad_edge) begin
      drift_q <= 1'b1;
    end
  end

  assign rx.drift_err = drift_q;
`else
  assign rx.drift_err = 1'b0;
`endif

endmodule
